// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the arbitrated UART transmitter:
//   - DEFAULT_CLK_FREQ / DEFAULT_BAUD_RATE : default timing constants
//   - tx_state_t                          : serializer FSM state type
//   - bit_cyc()                           : clock cycles per line bit
// Optional feature macro: UART_TX_ARB_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 27000000;
    localparam int DEFAULT_BAUD_RATE = 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_ARB_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    // Integer divide: any fractional remainder is dropped.
    function automatic int bit_cyc(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core
// Single-channel UART serializer: baud counter, shift register and frame FSM.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1); every bit
// lasts exactly BIT_CYC clock cycles.
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      load data_byte and begin a frame (honoured only when idle)
//   data_byte  byte to send, sampled on the accepting edge
//   busy       high while a frame is on the line
//   tx         registered serial output, idle high
// Optional feature macro: UART_TX_ARB_PARITY_EN (inserts the PARITY bit).
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BIT_CYC = bit_cyc(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_byte,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, shreg_n;
    logic             tx_n;
    logic             busy_n;
    logic             baud_done;
`ifdef UART_TX_ARB_PARITY_EN
    logic             par, par_n;
`endif

    assign baud_done = (baud_cnt == CNT_LAST);

    // Next-state logic. tx and busy are computed from the *next* state so the
    // line output comes straight from a flop and lines up with the state.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
        par_n   = par;
`endif

        if (state != ST_IDLE) begin
            baud_n = baud_done ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_START;
                    baud_n  = '0;
                    bit_n   = '0;
                    shreg_n = data_byte;
`ifdef UART_TX_ARB_PARITY_EN
                    par_n   = ^data_byte;
`endif
                end
            end
            ST_START: begin
                if (baud_done) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (baud_done) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            ST_PARITY: begin
                if (baud_done) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_ARB_PARITY_EN
            ST_PARITY: tx_n = par_n;
`endif
            default:   tx_n = 1'b1;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            busy     <= busy_n;
`ifdef UART_TX_ARB_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter in front of a single UART transmitter. Requesters hold
// req[i] with their byte on data[8i+7:8i]; the winner gets a one-cycle ack on
// the cycle its start bit begins.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset
//   req   per-requester level request, held until ack
//   data  packed request bytes, byte i at [8i+7:8i]
//   ack   one-cycle grant pulse, at most one bit set
//   busy  high while a frame is on the line
//   tx    serial line, idle high
// Optional feature macro: UART_TX_ARB_PARITY_EN (even parity bit, 11-bit frame).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int N_REQ     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] data,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic               tx
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             grant;
    logic [7:0]       sel_byte;
    int               idx;

    // Rotating search starting one past the previous grant, so the most
    // recently served requester is considered last.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDX_W'(i)) sel_byte = data[i*8 +: 8];
        end
    end

    // The core only accepts start while idle, so gating on busy keeps the
    // arbiter and the serializer in agreement about when a grant happened.
    assign grant = found && !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack        <= '0;
            last_grant <= LAST_IDX;
        end else begin
            ack <= '0;
            if (grant) begin
                ack        <= N_REQ'(1) << winner;
                last_grant <= winner;
            end
        end
    end

    uart_tx_core #(
        .BIT_CYC (BIT_CYC)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (grant),
        .data_byte (sel_byte),
        .busy      (busy),
        .tx        (tx)
    );

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb with a short bit period (16 cycles).
// Expected frames are built from the byte (start, data LSB first, optional
// even parity, stop); grant order comes from a round-robin reference pointer.
// Optional feature macro: UART_TX_ARB_PARITY_EN (expects 11-bit frames).
module tb_uart_tx_arb;

    localparam int CLK_FREQ  = 160;
    localparam int BAUD_RATE = 10;
    localparam int N_REQ     = 4;
    localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int ACK_BUDGET = 3 * NBITS * BIT_CYC;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ*8-1:0] data = '0;
    logic [N_REQ-1:0]   ack;
    logic               busy;
    logic               tx;

    int   total = 0;
    int   bad   = 0;
    int   mdlLast;
    bit   monOn = 1'b0;
    logic [7:0] byteOf [N_REQ];

    uart_tx_arb #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .N_REQ     (N_REQ)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .data (data),
        .ack  (ack),
        .busy (busy),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    // Continuous invariants: one grant at most, line idle whenever not busy.
    always @(negedge clk) begin
        if (monOn && !rst) begin
            total++;
            assert ($onehot0(ack)) else begin
                bad++;
                $error("[TB] FAIL ack_onehot0 observed=%b expected=at most one bit", ack);
            end
            total++;
            assert (busy === 1'b1 || tx === 1'b1) else begin
                bad++;
                $error("[TB] FAIL tx_idle_high observed=%b expected=1 (busy=%b)", tx, busy);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic packData();
        for (int i = 0; i < N_REQ; i++) data[i*8 +: 8] = byteOf[i];
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r);
        @(negedge clk);
        packData();
        req = r;
    endtask

    // Reference arbiter: first requester at or after (last grant + 1).
    function automatic int nextWinner(input logic [N_REQ-1:0] r);
        for (int k = 1; k <= N_REQ; k++) begin
            int i;
            i = (mdlLast + k) % N_REQ;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic frameBit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NBITS - 1) return 1'b1;
        return ^b;
    endfunction

    // Waits for a grant; on seeing it, the requester drops its request.
    task automatic waitAck(input int who, output bit got);
        got = 1'b0;
        for (int i = 0; i < ACK_BUDGET; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("ack_req%0d", who), 32'(ack), 32'(1) << who);
        if (got) begin
            req[who] = 1'b0;
            mdlLast  = who;
        end
    endtask

    // Called on the ack cycle: checks every cycle of the frame, then idle.
    task automatic checkFrame(input int who);
        logic [7:0] b;
        int errs;
        b = byteOf[who];
        for (int k = 0; k < NBITS; k++) begin
            errs = 0;
            for (int c = 0; c < BIT_CYC; c++) begin
                if (k != 0 || c != 0) begin
                    @(negedge clk);
                    if (ack !== '0) errs++;
                end
                if (tx !== frameBit(b, k) || busy !== 1'b1) errs++;
            end
            checkOutput($sformatf("req%0d_bit%0d_errs", who, k), errs, 0);
        end
        @(negedge clk);
        checkOutput("busy_after_frame", 32'(busy), 0);
        checkOutput("tx_after_frame", 32'(tx), 1);
    endtask

    task automatic receiveFrame(input int who);
        bit got;
        waitAck(who, got);
        if (got) checkFrame(who);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdlLast = N_REQ - 1;
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] dirBytes [4];
        logic [N_REQ-1:0] r;
        int seen;
        bit got;

        dirBytes[0] = 8'h55;
        dirBytes[1] = 8'h07;
        dirBytes[2] = 8'h03;
        dirBytes[3] = 8'($urandom);
        for (int i = 0; i < N_REQ; i++) byteOf[i] = '0;

        // Reset state
        mdlLast = N_REQ - 1;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("pkg_bit_cyc_default",
                    uart_pkg::bit_cyc(uart_pkg::DEFAULT_CLK_FREQ, uart_pkg::DEFAULT_BAUD_RATE),
                    2812);
        rst = 1'b0;
        mdlLast = N_REQ - 1;
        monOn = 1'b1;

        // Single requester 0: 0x55, parity patterns 0x07/0x03, one random byte
        for (int t = 0; t < 4; t++) begin
            byteOf[0] = dirBytes[t];
            applyStimulus(4'b0001);
            receiveFrame(nextWinner(req));
        end

        // All four held after reset: order 0,1,2,3, then 0101 gives 0,2
        doReset();
        base = 8'($urandom);
        for (int i = 0; i < N_REQ; i++) byteOf[i] = base + 8'(i * 61);
        applyStimulus(4'b1111);
        for (int i = 0; i < N_REQ; i++) receiveFrame(nextWinner(req));
        for (int i = 0; i < N_REQ; i++) byteOf[i] = 8'($urandom);
        applyStimulus(4'b0101);
        for (int i = 0; i < 2; i++) receiveFrame(nextWinner(req));

        // req[1] pulsed for one cycle while busy must be ignored
        byteOf[3] = 8'($urandom);
        applyStimulus(4'b1000);
        waitAck(3, got);
        repeat (20) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        for (int i = 0; i < NBITS * BIT_CYC + 5; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        checkOutput("withdrawn_busy_fell", 32'(busy), 0);
        seen = 0;
        for (int i = 0; i < 3 * BIT_CYC; i++) begin
            @(negedge clk);
            if (ack !== '0 || busy !== 1'b0) seen++;
        end
        checkOutput("withdrawn_no_ack", seen, 0);

        // Reset mid-frame aborts; afterwards req[2] alone wins
        byteOf[0] = 8'($urandom);
        applyStimulus(4'b0001);
        waitAck(0, got);
        repeat (5 * BIT_CYC + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx", 32'(tx), 1);
        checkOutput("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        mdlLast = N_REQ - 1;
        seen = 0;
        for (int i = 0; i < 2 * BIT_CYC; i++) begin
            @(negedge clk);
            if (ack !== '0 || busy !== 1'b0 || tx !== 1'b1) seen++;
        end
        checkOutput("midrst_no_resend", seen, 0);
        byteOf[2] = 8'($urandom);
        applyStimulus(4'b0100);
        receiveFrame(nextWinner(req));

        // Reset wins over a simultaneous grant
        @(negedge clk);
        byteOf[1] = 8'($urandom);
        packData();
        rst = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        checkOutput("rstprio_ack", 32'(ack), 0);
        checkOutput("rstprio_busy", 32'(busy), 0);
        rst = 1'b0;
        mdlLast = N_REQ - 1;
        receiveFrame(nextWinner(req));

        // Random request sets and bytes against the reference pointer
        for (int round = 0; round < 4; round++) begin
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) byteOf[i] = 8'($urandom);
            applyStimulus(r);
            for (int n = 0; n < N_REQ; n++) begin
                if (req != '0) receiveFrame(nextWinner(req));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
